// File: rtl/prio_decoder.sv
// prio_decoder: registered 2-to-4 one-hot decoder with valid/ready handshake.
// Drives x_out one-hot for PULSE_LEN cycles per accepted index. It then holds
// x_out at zero for GAP_LEN cycles and spends at least one IDLE cycle before
// it accepts the next index.
module prio_decoder #(
  parameter int unsigned PULSE_LEN = 4,  // 1..255
  parameter int unsigned GAP_LEN   = 1   // 0..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] y,
  output logic       in_ready,
  output logic [3:0] x_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] accept_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  // Counter reload values. The GAP reload is guarded so that GAP_LEN=0 cannot underflow.
  localparam logic [7:0] PULSE_M1 = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_M1   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

  state_t     state_q, state_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [3:0] x_q,     x_d;
  logic [7:0] acc_q,   acc_d;

  // State, down-counter, one-hot output and accept counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state logic. The index is sampled only on the accept edge in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        x_d = '0;
        if (in_valid) begin
          x_d     = 4'b0001 << y;
          cnt_d   = PULSE_M1;
          state_d = DRIVE;
          acc_d   = acc_q + 8'd1;  // wraps 255 -> 0
        end
      end
      DRIVE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (GAP_LEN > 0) begin
          state_d = GAP;
          cnt_d   = GAP_M1;
          x_d     = '0;
        end else begin
          state_d = IDLE;
          x_d     = '0;
        end
      end
      GAP: begin
        x_d = '0;
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        x_d     = '0;
      end
    endcase
  end

  // Status outputs are decoded directly from the registered state.
  // in_ready is masked by rst so that it drops at once when reset is asserted.
  assign in_ready   = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DRIVE) && (cnt_q == 8'd0);
  assign x_out      = x_q;
  assign accept_cnt = acc_q;

endmodule

// File: tb/tb_prio_decoder.sv
// Bench for prio_decoder. Instance A uses the default parameters (4,1).
// Instance B uses the boundary parameters (1,0).
module tb_prio_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, v_a, v_b;
  logic [1:0] y_a, y_b;
  logic       rdy_a, rdy_b, busy_a, busy_b, done_a, done_b;
  logic [3:0] x_a, x_b;
  logic [7:0] acc_a, acc_b;

  prio_decoder #(.PULSE_LEN(4), .GAP_LEN(1)) u_a (
    .clk(clk), .rst(rst_a), .in_valid(v_a), .y(y_a), .in_ready(rdy_a),
    .x_out(x_a), .busy(busy_a), .done(done_a), .accept_cnt(acc_a));

  prio_decoder #(.PULSE_LEN(1), .GAP_LEN(0)) u_b (
    .clk(clk), .rst(rst_b), .in_valid(v_b), .y(y_b), .in_ready(rdy_b),
    .x_out(x_b), .busy(busy_b), .done(done_b), .accept_cnt(acc_b));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [1:0] y;
    logic [3:0] x;
    logic       rdy;
    logic       busy;
    logic       done;
    logic [7:0] acc;
    logic       lb;    // loopback check applies this cycle
    logic [1:0] ly;    // index expected back from the encoder
  } vec_t;

  vec_t tbl[$];

  // Reference 4-to-2 priority encoder (highest set bit wins).
  function automatic logic [1:0] prio_enc(input logic [3:0] x);
    if (x[3])      return 2'd3;
    else if (x[2]) return 2'd2;
    else if (x[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h (x,rdy,busy,done,acc) expected %h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string name, input logic [3:0] x, input logic rdy,
                       input logic bsy, input logic dn, input logic [7:0] acc);
    chk(name, {x_a, rdy_a, busy_a, done_a, acc_a}, {x, rdy, bsy, dn, acc});
  endtask

  task automatic chk_b(input string name, input logic [3:0] x, input logic rdy,
                       input logic bsy, input logic dn, input logic [7:0] acc);
    chk(name, {x_b, rdy_b, busy_b, done_b, acc_b}, {x, rdy, bsy, dn, acc});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    v_a = 1'b0; v_b = 1'b0; y_a = 2'd0; y_b = 2'd0;

    // Build the vector table. Each entry gives the inputs for one cycle and
    // the outputs expected in that same cycle (before the next edge).
    // in_valid stays high through DRIVE and GAP with a y that differs from the
    // accepted index. This must be ignored.
    tbl.push_back('{v:1'b0, y:2'd1, x:4'b0000, rdy:1'b1, busy:1'b0, done:1'b0,
                    acc:8'd0, lb:1'b0, ly:2'd0});
    for (int p = 0; p < 4; p++) begin
      logic [1:0] yv;
      yv = 2'(3 - p);
      tbl.push_back('{v:1'b1, y:yv, x:4'b0000, rdy:1'b1, busy:1'b0, done:1'b0,
                      acc:8'(p), lb:1'b0, ly:2'd0});
      for (int c = 1; c <= 4; c++)
        tbl.push_back('{v:1'b1, y:yv ^ 2'((c % 3) + 1), x:4'b0001 << yv,
                        rdy:1'b0, busy:1'b1, done:(c == 4), acc:8'(p + 1),
                        lb:1'b1, ly:yv});
      tbl.push_back('{v:1'b1, y:yv ^ 2'd1, x:4'b0000, rdy:1'b0, busy:1'b1,
                      done:1'b0, acc:8'(p + 1), lb:1'b0, ly:2'd0});
    end
    tbl.push_back('{v:1'b0, y:2'd2, x:4'b0000, rdy:1'b1, busy:1'b0, done:1'b0,
                    acc:8'd4, lb:1'b0, ly:2'd0});

    // Reset state: in_ready is masked while rst is high.
    #1;
    chk_a("reset_a", 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
    chk_b("reset_b", 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
    #1 rst_a = 1'b0;
    #1 chk_a("rst_release_a", 4'b0000, 1'b1, 1'b0, 1'b0, 8'd0);

    // Table-driven decode, handshake hold and loopback through the encoder.
    foreach (tbl[i]) begin
      v_a = tbl[i].v;
      y_a = tbl[i].y;
      chk_a($sformatf("vec%0d", i), tbl[i].x, tbl[i].rdy, tbl[i].busy,
            tbl[i].done, tbl[i].acc);
      if (tbl[i].lb) begin
        checks++;
        if (prio_enc(x_a) !== tbl[i].ly) begin
          errors++;
          $display("FAIL loopback%0d: got %0d expected %0d", i, prio_enc(x_a), tbl[i].ly);
        end
      end
      tick();
    end

    // Assert reset during the 2nd DRIVE cycle. All outputs clear at once.
    v_a = 1'b1; y_a = 2'd1;
    tick();
    v_a = 1'b0;
    chk_a("mid_drive1", 4'b0010, 1'b0, 1'b1, 1'b0, 8'd5);
    tick();
    #2 rst_a = 1'b1;
    #1 chk_a("rst_mid", 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk) rst_a = 1'b0;
    #1 chk_a("rst_mid_release", 4'b0000, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_a("post_rst_idle", 4'b0000, 1'b1, 1'b0, 1'b0, 8'd0);
    end
    // The first accept after reset produces a full 4-cycle pulse.
    v_a = 1'b1; y_a = 2'd0;
    tick();
    v_a = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk_a($sformatf("post_rst_pulse%0d", c), 4'b0001, 1'b0, 1'b1, (c == 4), 8'd1);
      tick();
    end
    chk_a("post_rst_gap", 4'b0000, 1'b0, 1'b1, 1'b0, 8'd1);
    tick();
    chk_a("post_rst_idle2", 4'b0000, 1'b1, 1'b0, 1'b0, 8'd1);

    // Boundary instance: PULSE_LEN=1, GAP_LEN=0, in_valid held high with y=2.
    // The expected pattern is 0100,0000 repeating, with done on every other cycle.
    // Run to 256 accepts to cover the counter wrap.
    rst_b = 1'b0;
    #1;
    for (int c = 0; c < 512; c++) begin
      v_b = 1'b1; y_b = 2'd2;
      if (c < 8 || c >= 508)
        chk_b($sformatf("b_cyc%0d", c), (c % 2 == 1) ? 4'b0100 : 4'b0000,
              (c % 2 == 0), (c % 2 == 1), (c % 2 == 1), 8'((c + 1) / 2));
      tick();
    end
    v_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
